// File: rtl/register_file_sb.sv
// Parametrised register file with a per-register pending scoreboard and an
// outstanding-writes counter for RAW hazard detection between decode and writeback.
module register_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_register,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_register1,
   input  logic [ADDR_W-1:0] read_register2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_register,
   output logic              pending1,
   output logic              pending2,
   output logic [ADDR_W:0]   outstanding
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pending_q;
   logic [DEPTH-1:0]  pending_d;
   logic [CNT_W-1:0]  outstanding_q;
   logic [CNT_W-1:0]  outstanding_d;

   logic wr_zero;
   logic iss_zero;
   logic rd1_zero;
   logic rd2_zero;
   logic wr_eff;
   logic set_eff;
   logic set_new;
   logic clr_eff;

   // Address-0 masking applies only when the hardwired zero register is enabled.
   assign wr_zero  = ZERO_REG && (write_register == '0);
   assign iss_zero = ZERO_REG && (issue_register == '0);
   assign rd1_zero = ZERO_REG && (read_register1 == '0);
   assign rd2_zero = ZERO_REG && (read_register2 == '0);

   assign wr_eff  = reg_write && !wr_zero;
   assign set_eff = issue_valid && !iss_zero;
   assign set_new = set_eff && !pending_q[issue_register];
   // A same-register issue keeps the bit set, so the write does not retire it.
   assign clr_eff = wr_eff && pending_q[write_register] &&
                    !(set_eff && (issue_register == write_register));

   // Scoreboard and counter next state.
   always_comb begin
      pending_d     = pending_q;
      outstanding_d = outstanding_q;
      if (wr_eff) begin
         pending_d[write_register] = 1'b0;
      end
      if (set_eff) begin
         pending_d[issue_register] = 1'b1;
      end
      outstanding_d = outstanding_q + CNT_W'(set_new) - CNT_W'(clr_eff);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pending_q     <= '0;
         outstanding_q <= '0;
      end else begin
         if (wr_eff) begin
            regs_q[write_register] <= write_data;
         end
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
      end
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      read_data1 = regs_q[read_register1];
      read_data2 = regs_q[read_register2];
      pending1   = pending_q[read_register1];
      pending2   = pending_q[read_register2];
      if (BYPASS && wr_eff && (write_register == read_register1)) begin
         read_data1 = write_data;
         pending1   = 1'b0;
      end
      if (BYPASS && wr_eff && (write_register == read_register2)) begin
         read_data2 = write_data;
         pending2   = 1'b0;
      end
      if (rd1_zero) begin
         read_data1 = '0;
         pending1   = 1'b0;
      end
      if (rd2_zero) begin
         read_data2 = '0;
         pending2   = 1'b0;
      end
   end

   assign outstanding = outstanding_q;

endmodule
